// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the request/response handshake and the word-memory bus of the
//   load/store unit.
//
//   Request side : req_valid_i, req_ready_o, req_store_i, req_funct3_i,
//                  req_addr_i, req_wdata_i
//   Response side: resp_valid_o, resp_err_o, resp_rdata_o
//   Memory side  : mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
//                  mem_rdata_i
//
//   Modports:
//     master - the environment (core + data memory): drives requests and
//              memory read data, observes everything the LSU produces.
//     slave  - the load/store unit itself.
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_store_i;
    logic [2:0]            req_funct3_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;

    logic                  resp_valid_o;
    logic                  resp_err_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;

    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sits between the core datapath and a word-organised data memory. Takes one
//   load/store request at a time, issues word-aligned memory accesses, extracts
//   and extends byte/halfword load lanes, and performs read-modify-write for
//   byte/halfword stores (the memory only writes whole words).
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-low reset
//     bus    - load_store_unit_if.slave (request, response and memory bus)
//
//   Optional feature (compile-time macro LSU_MISALIGN_TRAP_EN):
//     defined   - H/HU with addr[0]=1 or W with addr[1:0]!=0 is rejected with
//                 resp_err_o and no memory access.
//     undefined - no misalignment detection; H/HU use lane addr[1], W ignores
//                 addr[1:0].
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t                state_reg;
    logic [2:0]            funct3_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  ready_reg;
    logic                  resp_valid_reg;
    logic                  resp_err_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  mem_read_reg;
    logic                  mem_write_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;

    // ------------------------------------------------------------------
    // Request legality, decoded straight from the request inputs so the
    // IDLE state can branch to RESP on the accept edge.
    // ------------------------------------------------------------------
    logic illegal_code;
    logic misaligned;
    logic req_illegal;

    always_comb begin
        illegal_code = 1'b0;
        if (bus.req_store_i) begin
            // Stores only exist as SB / SH / SW.
            illegal_code = bus.req_funct3_i[2] || (bus.req_funct3_i == 3'b011);
        end else begin
            // Loads: 011 (LD), 110 (LWU), 111 do not exist on RV32.
            illegal_code = (bus.req_funct3_i == 3'b011) ||
                           (bus.req_funct3_i[2:1] == 2'b11);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                        ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_illegal = illegal_code || misaligned;

    // ------------------------------------------------------------------
    // Load lane extraction and extension (used in LOAD).
    // ------------------------------------------------------------------
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;

    assign load_byte = bus.mem_rdata_i[{addr_reg[1:0], 3'b000} +: 8];
    assign load_half = bus.mem_rdata_i[{addr_reg[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'd0, load_byte};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = bus.mem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Store merge for read-modify-write (used in RMW_RD). Each byte lane
    // takes either the fresh store data or the word just read back.
    // ------------------------------------------------------------------
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] merged_word;

    always_comb begin
        byte_en = 4'b0000;
        case (funct3_reg[1:0])
            2'b00:   byte_en[addr_reg[1:0]] = 1'b1;
            2'b01:   byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            // SB replicates wdata[7:0] into every lane; SH replicates wdata[15:0]
            // so the even lane takes the low byte and the odd lane the high byte.
            assign merged_word[gi*8 +: 8] =
                byte_en[gi] ? (funct3_reg[0] ? wdata_reg[(gi%2)*8 +: 8] : wdata_reg[7:0])
                            : bus.mem_rdata_i[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM. Every output is a register loaded on the transition
    // into the state that owns it, so outputs never glitch on state decode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            funct3_reg     <= 3'd0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            ready_reg      <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            rdata_reg      <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Ready rises on the first edge after reset release.
                    ready_reg <= 1'b1;
                    if (bus.req_valid_i && ready_reg) begin
                        ready_reg  <= 1'b0;
                        funct3_reg <= bus.req_funct3_i;
                        addr_reg   <= bus.req_addr_i;
                        wdata_reg  <= bus.req_wdata_i;
                        if (req_illegal) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                        end else if (!bus.req_store_i) begin
                            state_reg    <= LOAD;
                            mem_read_reg <= 1'b1;
                        end else if (bus.req_funct3_i[1:0] == 2'b10) begin
                            state_reg     <= STORE;
                            mem_write_reg <= 1'b1;
                            mem_wdata_reg <= bus.req_wdata_i;
                        end else begin
                            state_reg    <= RMW_RD;
                            mem_read_reg <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rdata_reg      <= load_ext;
                    mem_read_reg   <= 1'b0;
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                end
                STORE: begin
                    mem_write_reg  <= 1'b0;
                    mem_wdata_reg  <= '0;
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                end
                RMW_RD: begin
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b1;
                    mem_wdata_reg <= merged_word;
                    state_reg     <= RMW_WR;
                end
                RMW_WR: begin
                    mem_write_reg  <= 1'b0;
                    mem_wdata_reg  <= '0;
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                end
                RESP: begin
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    ready_reg      <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg      <= IDLE;
                    ready_reg      <= 1'b0;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    mem_read_reg   <= 1'b0;
                    mem_write_reg  <= 1'b0;
                    mem_wdata_reg  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = ready_reg;
    assign bus.resp_valid_o = resp_valid_reg;
    assign bus.resp_err_o   = resp_err_reg;
    assign bus.resp_rdata_o = rdata_reg;
    assign bus.mem_read_o   = mem_read_reg;
    assign bus.mem_write_o  = mem_write_reg;
    assign bus.mem_addr_o   = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata_o  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A byte-addressed reference memory
//   models what loads and stores should do; a separate word memory is what the
//   DUT actually reads and writes. Directed cases first, then random traffic.
//   Build with +define+LSU_MISALIGN_TRAP_EN to exercise the misalignment trap.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if lsu_bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (lsu_bus)
    );

    // Physical word memory seen by the DUT (address bits [11:2]).
    bit [31:0] phys [1024];
    // Reference byte memory (address bits [11:0]).
    bit [7:0]  ref_mem [4096];

    logic [31:0] exp_rdata = 32'd0;
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          last_lat  = 0;
    logic        last_err  = 1'b0;

    assign lsu_bus.mem_rdata_i = phys[lsu_bus.mem_addr_o[11:2]];

    always @(posedge clk) begin
        if (lsu_bus.mem_write_o)
            phys[lsu_bus.mem_addr_o[11:2]] <= lsu_bus.mem_wdata_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_illegal(input bit st, input bit [2:0] f3, input bit [31:0] a);
        bit bad;
        if (st) bad = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    bad = (f3 inside {3'b011, 3'b110, 3'b111});
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0] != 1'b0) bad = 1'b1;
        if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
`else
        if (a == 32'h0 && f3 == 3'b111) bad = bad; // address has no effect on legality
`endif
        return bad;
    endfunction

    function automatic int word_base(input bit [31:0] a);
        return int'(a[11:0]) & ~3;
    endfunction

    function automatic bit [31:0] ref_word(input bit [31:0] a);
        int b = word_base(a);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a);
        int b = word_base(a);
        int hb = b + 2 * int'(a[1]);
        bit [31:0] v;
        case (f3[1:0])
            2'b00: begin
                v = 32'(ref_mem[b + int'(a[1:0])]);
                if (!f3[2] && v >= 32'd128) v = v - 32'd256;
            end
            2'b01: begin
                v = 32'(ref_mem[hb]) + 32'(ref_mem[hb+1]) * 32'd256;
                if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = ref_word(a);
        endcase
        return v;
    endfunction

    task automatic ref_store(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        int b = word_base(a);
        int hb = b + 2 * int'(a[1]);
        case (f3[1:0])
            2'b00: ref_mem[b + int'(a[1:0])] = wd[7:0];
            2'b01: begin
                ref_mem[hb]   = wd[7:0];
                ref_mem[hb+1] = wd[15:8];
            end
            default: begin
                for (int i = 0; i < 4; i++) ref_mem[b+i] = wd[8*i +: 8];
            end
        endcase
    endtask

    // ---------------- one transaction ----------------
    // Called and returns at a falling edge.
    task automatic do_req(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        bit          err;
        int          exp_lat = 0, exp_rd = -1, exp_wr = -1;
        logic [31:0] exp_wdata = 32'd0;
        int          lat = 0, rd_cnt = 0, wr_cnt = 0, rd_cyc = -1, wr_cyc = -1;
        logic        got_err = 1'b0;
        logic [31:0] wdata_seen = 32'd0;
        int          w = 0;

        err = ref_illegal(st, f3, a);
        if (err) begin
            exp_lat = 1;
        end else if (!st) begin
            exp_lat = 2; exp_rd = 1;
            exp_rdata = ref_load(f3, a);
        end else begin
            ref_store(f3, a, wd);
            exp_wdata = ref_word(a);
            if (f3 == 3'b010) begin exp_lat = 2; exp_wr = 1; end
            else begin exp_lat = 3; exp_rd = 1; exp_wr = 2; end
        end

        while (lsu_bus.req_ready_o !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", {31'd0, lsu_bus.req_ready_o}, 32'd1);

        lsu_bus.req_valid_i  = 1'b1;
        lsu_bus.req_store_i  = st;
        lsu_bus.req_funct3_i = f3;
        lsu_bus.req_addr_i   = a;
        lsu_bus.req_wdata_i  = wd;
        @(posedge clk);
        #1;
        // Scramble the request lines; the DUT must have latched them.
        lsu_bus.req_valid_i  = 1'b0;
        lsu_bus.req_store_i  = 1'($urandom);
        lsu_bus.req_funct3_i = 3'($urandom);
        lsu_bus.req_addr_i   = $urandom;
        lsu_bus.req_wdata_i  = $urandom;

        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("both_en", {31'd0, lsu_bus.mem_read_o & lsu_bus.mem_write_o}, 32'd0);
            check("ready_busy", {31'd0, lsu_bus.req_ready_o}, 32'd0);
            if (!lsu_bus.mem_write_o) check("wdata_idle", lsu_bus.mem_wdata_o, 32'd0);
            if (lsu_bus.mem_read_o || lsu_bus.mem_write_o)
                check("mem_addr", lsu_bus.mem_addr_o, {a[31:2], 2'b00});
            if (lsu_bus.mem_read_o) begin rd_cnt++; rd_cyc = k; end
            if (lsu_bus.mem_write_o) begin wr_cnt++; wr_cyc = k; wdata_seen = lsu_bus.mem_wdata_o; end
            if (lsu_bus.resp_valid_o) begin
                lat = k;
                got_err = lsu_bus.resp_err_o;
                break;
            end
        end

        check("latency", lat, exp_lat);
        check("resp_err", {31'd0, got_err}, {31'd0, err});
        check("rdata", lsu_bus.resp_rdata_o, exp_rdata);
        check("rd_cycle", rd_cyc, exp_rd);
        check("wr_cycle", wr_cyc, exp_wr);
        check("rd_count", rd_cnt, (exp_rd > 0) ? 1 : 0);
        check("wr_count", wr_cnt, (exp_wr > 0) ? 1 : 0);
        if (exp_wr > 0) check("mem_wdata", wdata_seen, exp_wdata);
        if (st && !err) check("mem_word", phys[a[11:2]], ref_word(a));

        $display("[TB] txn %s f3=%03b addr=0x%08h wdata=0x%08h lat=%0d err=%0b rdata=0x%08h",
                 st ? "ST" : "LD", f3, a, wd, lat, got_err, lsu_bus.resp_rdata_o);
        last_lat = lat;
        last_err = got_err;

        @(negedge clk);
        check("resp_pulse", {31'd0, lsu_bus.resp_valid_o}, 32'd0);
        check("ready_after", {31'd0, lsu_bus.req_ready_o}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit [2:0]  f3;
        bit [31:0] a;
        bit        st;

        // Reset with a request pending: nothing may happen.
        lsu_bus.req_valid_i  = 1'b1;
        lsu_bus.req_store_i  = 1'b1;
        lsu_bus.req_funct3_i = 3'b010;
        lsu_bus.req_addr_i   = 32'h0000_0100;
        lsu_bus.req_wdata_i  = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, lsu_bus.req_ready_o}, 32'd0);
        check("rst_resp_valid", {31'd0, lsu_bus.resp_valid_o}, 32'd0);
        check("rst_resp_err", {31'd0, lsu_bus.resp_err_o}, 32'd0);
        check("rst_rdata", lsu_bus.resp_rdata_o, 32'd0);
        check("rst_mem_read", {31'd0, lsu_bus.mem_read_o}, 32'd0);
        check("rst_mem_write", {31'd0, lsu_bus.mem_write_o}, 32'd0);
        check("rst_mem_addr", lsu_bus.mem_addr_o, 32'd0);
        check("rst_mem_wdata", lsu_bus.mem_wdata_o, 32'd0);

        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, lsu_bus.req_ready_o}, 32'd1);
        check("no_accept_in_reset", {31'd0, lsu_bus.mem_write_o}, 32'd0);
        lsu_bus.req_valid_i = 1'b0;
        @(negedge clk);

        // SW then LW.
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        check("sw_latency", last_lat, 2);
        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw_value", lsu_bus.resp_rdata_o, 32'hDEADBEEF);

        // Misaligned word load.
        do_req(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_misalign_err", {31'd0, last_err}, 32'd1);
`else
        check("lw_misalign_word", lsu_bus.resp_rdata_o, 32'hDEADBEEF);
`endif

        // Sub-word loads.
        do_req(1'b1, 3'b010, 32'h200, 32'h80FF7F01);
        do_req(1'b0, 3'b000, 32'h203, 32'h0);
        check("lb_value", lsu_bus.resp_rdata_o, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h203, 32'h0);
        check("lbu_value", lsu_bus.resp_rdata_o, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h200, 32'h0);
        check("lh_value", lsu_bus.resp_rdata_o, 32'h00007F01);
        do_req(1'b0, 3'b101, 32'h202, 32'h0);
        check("lhu_value", lsu_bus.resp_rdata_o, 32'h000080FF);

        // SB read-modify-write.
        do_req(1'b1, 3'b010, 32'h300, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h301, 32'hFFFFFFAA);
        check("sb_latency", last_lat, 3);
        check("sb_word", phys[32'h300 >> 2], 32'h1122AA44);

        // Illegal store code.
        do_req(1'b1, 3'b100, 32'h300, 32'h55555555);
        check("st100_err", {31'd0, last_err}, 32'd1);
        check("st100_latency", last_lat, 1);
        check("st100_rdata_held", lsu_bus.resp_rdata_o, 32'h000080FF);

        // Wrap-around address.
        do_req(1'b1, 3'b000, 32'hFFFFFFFF, 32'h0000005A);
        do_req(1'b0, 3'b100, 32'hFFFFFFFF, 32'h0);
        check("wrap_lbu", lsu_bus.resp_rdata_o, 32'h0000005A);

        // Reset during RMW_RD of SH 0x400.
        do_req(1'b1, 3'b010, 32'h400, 32'hCAFEF00D);
        lsu_bus.req_valid_i  = 1'b1;
        lsu_bus.req_store_i  = 1'b1;
        lsu_bus.req_funct3_i = 3'b001;
        lsu_bus.req_addr_i   = 32'h400;
        lsu_bus.req_wdata_i  = 32'h00001234;
        @(posedge clk);
        #1;
        lsu_bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("rmw_rd_active", {31'd0, lsu_bus.mem_read_o}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_read", {31'd0, lsu_bus.mem_read_o}, 32'd0);
        check("abort_write", {31'd0, lsu_bus.mem_write_o}, 32'd0);
        check("abort_ready", {31'd0, lsu_bus.req_ready_o}, 32'd0);
        check("abort_rdata", lsu_bus.resp_rdata_o, 32'd0);
        exp_rdata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_untouched", phys[32'h400 >> 2], 32'hCAFEF00D);
        check("abort_idle_ready", {31'd0, lsu_bus.req_ready_o}, 32'd1);
        do_req(1'b0, 3'b010, 32'h400, 32'h0);
        check("abort_lw", lsu_bus.resp_rdata_o, 32'hCAFEF00D);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            case ($urandom_range(0, 3))
                0: a = 32'hFFFFF000 | 32'($urandom_range(0, 4095));
                1: a = 32'h500 + 32'($urandom_range(0, 63));
                default: a = 32'($urandom_range(0, 4095));
            endcase
            do_req(st, f3, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

endmodule
